// File: rtl/sr_cmd_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : sr_cmd_driver_if
//  Purpose  : Bundles the command handshake, the S/R drive pair and the
//             flip-flop read-back/status signals of sr_cmd_driver.
//  Signals  : cmd_valid, cmd_op[1:0]   command from control logic
//             cmd_ready                driver can accept a command
//             S, R                     drive to the SR flip-flop
//             q_model                  expected flip-flop Q
//             done                     one-cycle completion pulse
//             q_in                     actual flip-flop Q (read-back)
//             err                      sticky read-back mismatch flag
//  Modports : master - command source / flip-flop side
//             slave  - sr_cmd_driver
//  Revision : 1.0  initial release
// ============================================================================
interface sr_cmd_driver_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       S;
  logic       R;
  logic       q_model;
  logic       done;
  logic       q_in;
  logic       err;

  modport master (
    output cmd_valid, cmd_op, q_in,
    input  cmd_ready, S, R, q_model, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, q_in,
    output cmd_ready, S, R, q_model, done, err
  );
endinterface
`default_nettype wire

// File: rtl/sr_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module   : sr_cmd_driver
//  Purpose  : Turns one-at-a-time nop/clear/set/toggle commands into S/R
//             pulses of PULSE_W cycles followed by GAP_W guard cycles, and
//             keeps a shadow of the driven flip-flop's Q.
//  Params   : PULSE_W  S/R high time in cycles (1..255)
//             GAP_W    guard cycles with S=R=0 after a pulse (0..255)
//  Ports    : clk      clock, rising edge
//             reset    synchronous reset, active low
//             bus      sr_cmd_driver_if.slave (command handshake, S/R,
//                      q_model, done, q_in, err)
//  Option   : SR_CMD_DRIVER_CHECK_EN - when defined, q_in is compared with
//             q_model on every done cycle and a mismatch sets sticky err.
//             When undefined q_in is ignored and err is held at 0.
//  Revision : 1.0  initial release
// ============================================================================
module sr_cmd_driver #(
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned GAP_W   = 1
) (
  input  wire            clk,
  input  wire            reset,
  sr_cmd_driver_if.slave bus
);

  localparam logic [1:0] c_op_nop = 2'b00;
  localparam logic [1:0] c_op_set = 2'b10;
  localparam logic [1:0] c_op_tgl = 2'b11;

  // Counters hold "cycles remaining minus one"; out-of-range parameters just wrap.
  localparam logic [7:0] c_pulse_load = 8'(PULSE_W - 32'd1);
  localparam logic [7:0] c_gap_load   = 8'(GAP_W - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       q_model_q, q_model_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       alive_q;   // low through reset, so cmd_ready stays low until the cycle after release

  logic       w_cmd_ready;
  logic       w_accept;
  logic       w_want_set;

  assign w_cmd_ready = alive_q && (state_q == ST_IDLE);
  assign w_accept    = bus.cmd_valid && w_cmd_ready;
  // Toggle resolves against the shadow Q at accept time.
  assign w_want_set  = (bus.cmd_op == c_op_set) ||
                       ((bus.cmd_op == c_op_tgl) && !q_model_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      q_model_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      alive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      r_q       <= r_d;
      q_model_q <= q_model_d;
      done_q    <= done_d;
      err_q     <= err_d;
      alive_q   <= 1'b1;
    end
  end

  // S and R next-states are only ever produced as a complementary pair from
  // one decision, or as a hold that masks R with S, so they cannot both be 1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    q_model_d = q_model_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.cmd_op == c_op_nop) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_PULSE;
            cnt_d   = c_pulse_load;
            s_d     = w_want_set;
            r_d     = !w_want_set;
          end
        end
      end
      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          // Last pulse cycle: S/R drop and the shadow takes the driven value.
          q_model_d = s_q;
          if (GAP_W == 0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
            cnt_d   = c_gap_load;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
          s_d   = s_q;
          r_d   = r_q && !s_q;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef SR_CMD_DRIVER_CHECK_EN
  // The flip-flop has settled by the done cycle, so compare there.
  assign err_d = err_q || (done_q && (bus.q_in != q_model_q));
`else
  logic w_unused_q_in;
  assign w_unused_q_in = bus.q_in;
  assign err_d         = 1'b0;
`endif

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.q_model   = q_model_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_cmd_driver
//  Purpose  : Three sr_cmd_driver instances (PULSE_W/GAP_W = 1/1, 3/0, 4/2)
//             on one clock and reset, checked every cycle against a
//             timestamp-based model: each accepted command records when its
//             pulse starts/ends, when Q changes and when done/ready occur.
//             Directed scenarios are followed by randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sr_cmd_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] v_valid = 3'b000;
  logic [1:0] v_op [3];
  logic [2:0] v_qin   = 3'b000;

  logic [2:0] a_rdy, a_s, a_r, a_q, a_done, a_err;

  sr_cmd_driver_if if0 ();
  sr_cmd_driver_if if1 ();
  sr_cmd_driver_if if2 ();

  assign if0.cmd_valid = v_valid[0];
  assign if1.cmd_valid = v_valid[1];
  assign if2.cmd_valid = v_valid[2];
  assign if0.cmd_op    = v_op[0];
  assign if1.cmd_op    = v_op[1];
  assign if2.cmd_op    = v_op[2];
  assign if0.q_in      = v_qin[0];
  assign if1.q_in      = v_qin[1];
  assign if2.q_in      = v_qin[2];

  assign a_rdy  = {if2.cmd_ready, if1.cmd_ready, if0.cmd_ready};
  assign a_s    = {if2.S,         if1.S,         if0.S};
  assign a_r    = {if2.R,         if1.R,         if0.R};
  assign a_q    = {if2.q_model,   if1.q_model,   if0.q_model};
  assign a_done = {if2.done,      if1.done,      if0.done};
  assign a_err  = {if2.err,       if1.err,       if0.err};

  sr_cmd_driver #(.PULSE_W(1), .GAP_W(1)) u0 (.clk(clk), .reset(rst_n), .bus(if0));
  sr_cmd_driver #(.PULSE_W(3), .GAP_W(0)) u1 (.clk(clk), .reset(rst_n), .bus(if1));
  sr_cmd_driver #(.PULSE_W(4), .GAP_W(2)) u2 (.clk(clk), .reset(rst_n), .bus(if2));

`ifdef SR_CMD_DRIVER_CHECK_EN
  localparam bit C_EXP_ERR = 1'b1;
`else
  localparam bit C_EXP_ERR = 1'b0;
`endif

  // ---------------- behavioural model (per instance) ----------------
  // cyc = index of the current clock period (number of rising edges so far).
  longint cyc;
  longint m_free [3];   // first period in which cmd_ready is expected
  longint m_plo  [3];   // S/R high in periods [m_plo, m_phi)
  longint m_phi  [3];
  longint m_qat  [3];   // edge at which q_model takes m_qnew
  longint m_done [3];   // period in which done is expected
  bit     m_alive[3], m_set[3], m_q[3], m_qnew[3], m_err[3], m_acc[3];
  bit     ff     [3];   // the attached flip-flop's Q
  bit     force0 [3];   // hold q_in at 0 (fault on the flip-flop side)

  int n_vec  = 0;
  int n_miss = 0;

  function automatic int pw(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  function automatic int gw(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
  endfunction

  function automatic bit e_rdy(input int i);
    return m_alive[i] && (cyc >= m_free[i]);
  endfunction

  function automatic bit e_s(input int i);
    return m_set[i] && (cyc >= m_plo[i]) && (cyc < m_phi[i]);
  endfunction

  function automatic bit e_r(input int i);
    return !m_set[i] && (cyc >= m_plo[i]) && (cyc < m_phi[i]);
  endfunction

  task automatic model_reset(input int i);
    m_alive[i] = 1'b0;
    m_free[i]  = 0;
    m_plo[i]   = 0;
    m_phi[i]   = 0;
    m_qat[i]   = -1;
    m_done[i]  = -1;
    m_set[i]   = 1'b0;
    m_q[i]     = 1'b0;
    m_qnew[i]  = 1'b0;
    m_err[i]   = 1'b0;
  endtask

  // Called right after a rising edge; uses the inputs of the period that ended.
  task automatic model_edge();
    longint n;
    n = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = 1'b0;
      if (!rst_n) begin
        model_reset(i);
      end else begin
        if (C_EXP_ERR && (m_done[i] == cyc) && (v_qin[i] != m_q[i]))
          m_err[i] = 1'b1;
        if (m_qat[i] == n)
          m_q[i] = m_qnew[i];
        if (v_valid[i] && e_rdy(i)) begin
          m_acc[i] = 1'b1;
          if (v_op[i] == 2'b00) begin
            m_done[i] = n;
          end else begin
            m_set[i]  = (v_op[i] == 2'b10) || ((v_op[i] == 2'b11) && !m_q[i]);
            m_plo[i]  = n;
            m_phi[i]  = n + pw(i);
            m_qat[i]  = n + pw(i);
            m_qnew[i] = m_set[i];
            m_free[i] = n + pw(i) + gw(i);
            m_done[i] = n + pw(i) + gw(i);
          end
        end
        m_alive[i] = 1'b1;
      end
    end
    cyc = n;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.cmd_ready", i), a_rdy[i],  e_rdy(i));
      chk($sformatf("u%0d.S", i),         a_s[i],    e_s(i));
      chk($sformatf("u%0d.R", i),         a_r[i],    e_r(i));
      chk($sformatf("u%0d.q_model", i),   a_q[i],    m_q[i]);
      chk($sformatf("u%0d.done", i),      a_done[i], m_done[i] == cyc);
      chk($sformatf("u%0d.err", i),       a_err[i],  m_err[i]);
      chk($sformatf("u%0d.S_and_R", i),   a_s[i] & a_r[i], 1'b0);
    end
  endtask

  // One clock: model at the rising edge, compare at the falling edge, then
  // present the flip-flop's Q for the next period (it follows expected S/R).
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n)       ff[i] = 1'b0;
      else if (e_s(i))  ff[i] = 1'b1;
      else if (e_r(i))  ff[i] = 1'b0;
      v_qin[i] = force0[i] ? 1'b0 : ff[i];
    end
  endtask

  task automatic wait_ready(input int i);
    for (int t = 0; t < 64; t++) begin
      if (e_rdy(i)) break;
      step();
    end
    if (!e_rdy(i)) begin
      n_vec++;
      n_miss++;
      $display("FAIL u%0d.ready_timeout: got not-ready, expected ready within 64 cycles", i);
    end
  endtask

  // Present a command once the driver is ready; returns in the first pulse cycle.
  task automatic issue(input int i, input logic [1:0] op);
    wait_ready(i);
    v_valid[i] = 1'b1;
    v_op[i]    = op;
    step();
    v_valid[i] = 1'b0;
  endtask

  logic [7:0] hs, hr, hd, hq;

  initial begin
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      model_reset(i);
      m_acc[i]  = 1'b0;
      ff[i]     = 1'b0;
      force0[i] = 1'b0;
      v_op[i]   = 2'b00;
    end

    // Reset held for three cycles, then released.
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst.S", a_s[0], 1'b0);
    chk("rst.R", a_r[1], 1'b0);
    chk("rst.q_model", a_q[2], 1'b0);
    chk("rst.cmd_ready", a_rdy[0], 1'b0);
    chk("rst.err", a_err[0], 1'b0);
    rst_n = 1'b1;
    step();
    chk("rel.cmd_ready", a_rdy[0], 1'b1);

    // PULSE_W=1, GAP_W=1: set then clear.
    issue(0, 2'b10);
    chk("p1.set.S", a_s[0], 1'b1);
    step();
    chk("p1.set.S_drop", a_s[0], 1'b0);
    chk("p1.set.q_model", a_q[0], 1'b1);
    step();
    chk("p1.set.done", a_done[0], 1'b1);
    issue(0, 2'b01);
    chk("p1.clr.R", a_r[0], 1'b1);
    step();
    chk("p1.clr.R_drop", a_r[0], 1'b0);
    chk("p1.clr.q_model", a_q[0], 1'b0);

    // PULSE_W=3, GAP_W=0: two toggles with cmd_valid held high.
    wait_ready(1);
    v_valid[1] = 1'b1;
    v_op[1]    = 2'b11;
    hs = '0; hr = '0; hd = '0; hq = '0;
    for (int t = 0; t < 8; t++) begin
      step();
      hs = {hs[6:0], a_s[1]};
      hr = {hr[6:0], a_r[1]};
      hd = {hd[6:0], a_done[1]};
      hq = {hq[6:0], a_q[1]};
      if (t == 4) v_valid[1] = 1'b0;
    end
    chk8("p3.tgl.S_seq", hs, 8'b1110_0000);
    chk8("p3.tgl.R_seq", hr, 8'b0000_1110);
    chk8("p3.tgl.done_seq", hd, 8'b0001_0001);
    chk8("p3.tgl.q_seq", hq, 8'b0001_1110);

    // Nop while q_model=1.
    issue(0, 2'b10);
    wait_ready(0);
    issue(0, 2'b00);
    chk("nop.done", a_done[0], 1'b1);
    chk("nop.q_model", a_q[0], 1'b1);
    chk("nop.S", a_s[0], 1'b0);
    chk("nop.R", a_r[0], 1'b0);
    chk("nop.cmd_ready", a_rdy[0], 1'b1);

    // Reset in the second cycle of a PULSE_W=4 set.
    issue(2, 2'b10);
    step();
    chk("rmid.S_before", a_s[2], 1'b1);
    rst_n = 1'b0;
    step();
    chk("rmid.S", a_s[2], 1'b0);
    chk("rmid.q_model", a_q[2], 1'b0);
    chk("rmid.done", a_done[2], 1'b0);
    step();
    rst_n = 1'b1;
    step();
    issue(2, 2'b10);
    wait_ready(2);
    chk("rmid.after.q_model", a_q[2], 1'b1);

    // Flip-flop stuck at 0 after a set, then a clear, then reset.
    force0[0] = 1'b1;
    issue(0, 2'b10);
    wait_ready(0);
    step();
    chk("chk.err_set", a_err[0], C_EXP_ERR);
    force0[0] = 1'b0;
    issue(0, 2'b01);
    wait_ready(0);
    step();
    chk("chk.err_sticky", a_err[0], C_EXP_ERR);
    rst_n = 1'b0;
    step();
    step();
    chk("chk.err_reset", a_err[0], 1'b0);
    rst_n = 1'b1;
    step();

    // Randomized traffic with occasional read-back faults and resets.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v_valid[i] || m_acc[i]) begin
          v_valid[i] = ($urandom_range(0, 2) == 0);
          v_op[i]    = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 99) == 0) force0[i] = !force0[i];
      end
      rst_n = ($urandom_range(0, 249) != 0);
      step();
    end

    v_valid = 3'b000;
    rst_n   = 1'b1;
    repeat (12) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sr_cmd_driver.md
# sr_cmd_driver

Command-side driver for the team's clocked SR flip-flops: turns one-at-a-time set/clear/toggle/nop commands into well-formed S/R pulses. Guarantees S and R are never high together, holds each pulse for a programmable width, and inserts a guard gap before the next command. Keeps a shadow of the flip-flop's expected Q, and can compile in a read-back check of the real Q. It sits between control logic and an `SR_ff` instance, on the same clock.

## Interface
- `PULSE_W`, 1: cycles S or R is held high per set/clear; legal range 1..255.
- `GAP_W`, 1: guard cycles with S=R=0 after each pulse; legal range 0..255.

- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `cmd_valid`  in  1  command present.
- `cmd_op`  in  2  00 nop, 01 clear, 10 set, 11 toggle.
- `cmd_ready`  out  1  block can accept a command.
- `S`  out  1  set drive to flip-flop, registered.
- `R`  out  1  reset drive to flip-flop, registered.
- `q_model`  out  1  expected flip-flop Q.
- `done`  out  1  one-cycle pulse when a command completes.
- `q_in`  in  1  actual flip-flop Q (used only with the check feature).
- `err`  out  1  sticky mismatch flag.

## Operation
- States: IDLE, PULSE, GAP.
- Accept happens when `cmd_valid && cmd_ready`. `cmd_ready` = 1 only in IDLE.
- Op resolution at accept:
  - set → drive S.
  - clear → drive R.
  - toggle → drive R if `q_model`=1, else S.
  - nop → no drive.
- IDLE → PULSE on an accepted set/clear/toggle. Load the pulse counter with `PULSE_W`-1.
- Nop: stay in IDLE and assert `done` the next cycle. `q_model` is unchanged.
- PULSE: exactly one of S/R is high. Count down. At 0:
  - drop S/R;
  - update `q_model` (1 for S, 0 for R);
  - go to GAP with the counter at `GAP_W`-1, or straight to IDLE if `GAP_W`=0.
- GAP: S=R=0. At count 0 go to IDLE.
- `done` is high for one cycle, on the first IDLE cycle after a command finishes.
- Invariant: S&R is never 1 in any cycle, including reset and illegal parameters.
- Commands arriving while `cmd_ready`=0 are not accepted. The source holds `cmd_valid`/`cmd_op` stable until accepted.
- Reset values, and reset mid-operation: state=IDLE, S=0, R=0, `q_model`=0, `done`=0, `err`=0, `cmd_ready`=0. Any in-flight pulse is aborted at that edge. `cmd_ready` rises on the first cycle after `reset` returns to 1.
- Counter widths are 8 bits. Parameters outside the legal range are a configuration error and have no defined behaviour, apart from the S&R invariant.

## Timing
- A command accepted at edge k (set/clear/toggle):
  - S or R is high in cycles k+1 .. k+`PULSE_W`.
  - `q_model` updates at edge k+`PULSE_W`+1.
  - `done` is high in cycle k+`PULSE_W`+`GAP_W`+1, and `cmd_ready` is 1 in that same cycle.
- Back-to-back throughput: one command per `PULSE_W`+`GAP_W`+1 cycles.
- Nop accepted at edge k: `done` in cycle k+1, and `cmd_ready` stays 1.
- The `SR_ff` reacts one edge after S/R. Its Q is therefore settled by the `done` cycle whenever `PULSE_W` ≥ 1.

## Configuration
- Macro: `SR_CMD_DRIVER_CHECK_EN`.
- Defined: in every cycle where `done`=1, compare `q_in` with `q_model`. On mismatch, set `err` at the next edge; it stays set until reset.
- Undefined: `q_in` is ignored and `err` is tied to 0. All other behaviour is identical.

## Test plan
- Reset low for 3 cycles, then release → S=R=0, `q_model`=0, `err`=0 during reset; `cmd_ready`=1 in the first cycle after release.
- `PULSE_W`=1, `GAP_W`=1. Set accepted at edge k → S=1 only in cycle k+1; `q_model`=1 from k+2; `done` in k+3. Then clear → R one cycle wide; `q_model`=0.
- `PULSE_W`=3, `GAP_W`=0. Toggle twice with `cmd_valid` held high → S high 3 cycles, then R high 3 cycles; `q_model` goes 0→1→0; `done` every 4 cycles; S&R never 1.
- Nop with `q_model`=1 → no S/R activity; `done` next cycle; `q_model` stays 1.
- Reset asserted in the 2nd cycle of a `PULSE_W`=4 set → S=0 from the next cycle; `q_model`=0; no `done`; normal operation after release.
- With `SR_CMD_DRIVER_CHECK_EN`: `q_in` forced to 0 after a set → `err`=1 from the cycle after `done`, sticky across a later clear; cleared only by reset. Without the macro: same stimulus → `err` stays 0.
